reg_dump_sequencer: RTL and testbench

- Sweeps the simulation register interface (addr / register_value / finished_register) once per sweep request.
- Converts each 32-bit register value into 8 ASCII hex characters and hands them to the VGA text renderer over a valid/ready character-write port.
- Sits between the simulation environment and the character renderer inside vga_demo. It is the sole owner of addr.

---
 rtl/reg_dump_sequencer.sv | 146 ++++++++++++++
 tb/tb_reg_dump_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer
// Walks the simulation register interface one address at a time, waits out
// the read latency, captures each 32-bit register and streams it to the text
// renderer as 8 uppercase ASCII hex characters, most significant nibble first.
//
// Character port handshake: char_valid/char_code/char_x/char_y are held stable
// from the cycle char_valid rises until a rising edge where char_valid and
// char_ready are both high; that edge transfers exactly one character.
// char_ready is ignored while char_valid is low.
module reg_dump_sequencer #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 9,
    parameter int READ_LAT = 2,
    parameter int X_BASE   = 4,
    parameter int Y_BASE   = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    input  logic [31:0]       register_value,
    output logic              finished_register,
    output logic              busy,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [7:0]        char_code,
    output logic [6:0]        char_x,
    output logic [5:0]        char_y
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        EMIT,
        NEXT,
        DONE
    } state_t;

    // Last valid address of a sweep; addr stops here and never wraps.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    // The capture happens on the edge where the counter still reads READ_LAT-1,
    // which is the READ_LAT-th edge after addr was updated.
    localparam logic [2:0]        LAT_M1    = 3'(READ_LAT - 1);
    localparam logic [6:0]        X0        = 7'(X_BASE);
    localparam logic [5:0]        Y0        = 6'(Y_BASE);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [2:0]  nib;
    logic [2:0]  nib_next;
    logic [31:0] capture;

    // ASCII for one hex digit, uppercase letters.
    function automatic logic [7:0] to_hex(input logic [3:0] v);
        if (v < 4'd10) begin
            return 8'h30 + {4'h0, v};
        end
        return 8'h37 + {4'h0, v};
    endfunction

    // Nibble idx of w, counting from the most significant nibble.
    function automatic logic [3:0] nibble_at(input logic [31:0] w, input logic [2:0] idx);
        logic [4:0] hi;
        hi = 5'd31 - {idx, 2'b00};
        return w[hi -: 4];
    endfunction

    // Index of the character presented after the current one is accepted.
    always_comb begin
        nib_next = nib + 3'd1;
    end

    // Sweep sequencer: address walk, capture, and character presentation.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state             <= IDLE;
            addr              <= '0;
            finished_register <= 1'b0;
            busy              <= 1'b0;
            char_valid        <= 1'b0;
            char_code         <= 8'h00;
            char_x            <= 7'd0;
            char_y            <= 6'd0;
            wait_cnt          <= 3'd0;
            nib               <= 3'd0;
            capture           <= 32'h0;
        end else begin
            finished_register <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state    <= WAIT;
                        addr     <= '0;
                        wait_cnt <= 3'd0;
                        busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (wait_cnt == LAT_M1) begin
                        // The first character comes straight from the bus value,
                        // since capture only holds it after this edge.
                        capture    <= register_value;
                        nib        <= 3'd0;
                        char_valid <= 1'b1;
                        char_code  <= to_hex(register_value[31:28]);
                        char_x     <= X0;
                        char_y     <= Y0 + 6'(addr);
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (char_ready) begin
                        if (nib == 3'd7) begin
                            char_valid <= 1'b0;
                            state      <= NEXT;
                        end else begin
                            nib       <= nib_next;
                            char_code <= to_hex(nibble_at(capture, nib_next));
                            char_x    <= X0 + {4'b0000, nib_next};
                        end
                    end
                end
                NEXT: begin
                    if (addr == LAST_ADDR) begin
                        finished_register <= 1'b1;
                        state             <= DONE;
                    end else begin
                        addr     <= addr + 1'b1;
                        wait_cnt <= 3'd0;
                        state    <= WAIT;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Bench for reg_dump_sequencer: a 32-register instance fed through a 2-cycle
// read model, plus a single-register instance. Expected characters come from
// a per-sweep list built from the register contents.
module tb_reg_dump_sequencer;

    localparam int N  = 32;
    localparam int RL = 2;
    localparam int XB = 4;
    localparam int YB = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic        char_ready;
    logic [8:0]  addr;
    logic [31:0] register_value;
    logic        finished_register;
    logic        busy;
    logic        char_valid;
    logic [7:0]  char_code;
    logic [6:0]  char_x;
    logic [5:0]  char_y;

    logic        start1;
    logic        ready1;
    logic [8:0]  addr1;
    logic [31:0] rv1;
    logic        fin1;
    logic        busy1;
    logic        valid1;
    logic [7:0]  code1;
    logic [6:0]  x1;
    logic [5:0]  y1;

    // Register file of the simulated environment; reads take 2 cycles:
    // a registered address then a combinational lookup.
    logic [31:0] regs [N];
    logic [8:0]  a_d = 9'd0;
    always @(posedge clk) a_d <= addr;
    assign register_value = regs[a_d[4:0]];

    reg_dump_sequencer #(.NUM_REGS(N), .ADDR_W(9), .READ_LAT(RL), .X_BASE(XB), .Y_BASE(YB)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .addr(addr),
        .register_value(register_value), .finished_register(finished_register),
        .busy(busy), .char_valid(char_valid), .char_ready(char_ready),
        .char_code(char_code), .char_x(char_x), .char_y(char_y)
    );

    reg_dump_sequencer #(.NUM_REGS(1), .ADDR_W(9), .READ_LAT(RL), .X_BASE(XB), .Y_BASE(YB)) dut1 (
        .CLOCK_50(clk), .reset(reset), .start(start1), .addr(addr1),
        .register_value(rv1), .finished_register(fin1),
        .busy(busy1), .char_valid(valid1), .char_ready(ready1),
        .char_code(code1), .char_x(x1), .char_y(y1)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [20:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: one character = {ascii, column, row}.
    function automatic logic [20:0] char_word(input logic [31:0] val, input int a, input int n);
        string digits;
        int    nib;
        digits = "0123456789ABCDEF";
        nib    = int'((val >> (28 - 4 * n)) & 32'hF);
        return {8'(digits[nib]), 7'(XB + n), 6'((YB + a) % 64)};
    endfunction

    task automatic build_expected();
        exp_q.delete();
        for (int a = 0; a < N; a++) begin
            for (int n = 0; n < 8; n++) begin
                exp_q.push_back(char_word(regs[a], a, n));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // One full sweep of the 32-register instance. pct = char_ready duty in
    // percent; poke_at = cycle at which a stray start pulse is issued (0 = none).
    task automatic sweep(input int pct, input int poke_at);
        int          k = 0;
        int          fin_cnt = 0;
        int          fin_k = 0;
        int          busy_gap = 0;
        int          addr_over = 0;
        int          extra = 0;
        bit          done = 1'b0;
        bit          held_v = 1'b0;
        bit          rdy;
        logic [20:0] held = '0;
        logic [20:0] word;
        build_expected();
        start = 1'b1;
        while (!done && k < 5000) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (k == poke_at) start = 1'b1;
            if (k == poke_at + 1) start = 1'b0;
            word = {char_code, char_x, char_y};
            if (held_v) check("stall_hold", {10'b0, char_valid, word}, {10'b0, 1'b1, held});
            if (finished_register) begin
                fin_cnt++;
                fin_k = k;
                done  = 1'b1;
            end
            if (!busy) busy_gap++;
            if (addr > 9'(N - 1)) addr_over++;
            rdy        = ($urandom_range(99) < pct);
            char_ready = rdy;
            if (char_valid && rdy) begin
                if (exp_q.size() == 0) extra++;
                else check("char", 32'(word), 32'(exp_q.pop_front()));
                held_v = 1'b0;
            end else begin
                held_v = char_valid;
                held   = word;
            end
        end
        check("timeout", 32'(done), 32'd1);
        check("finish_pulses", fin_cnt, 1);
        // With no stalls the pulse lands after N*(RL+8+1) edges past the start edge.
        if (pct == 100) check("sweep_len", fin_k, N * (RL + 9) + 1);
        check("busy_gaps", busy_gap, 0);
        check("addr_range", addr_over, 0);
        check("extra_chars", extra, 0);
        check("chars_left", exp_q.size(), 0);
        check("last_addr", 32'(addr), N - 1);
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_fin", 32'(finished_register), 0);
        check("idle_addr", 32'(addr), N - 1);
    endtask

    // Reset while the fourth character of register 5 is being offered.
    task automatic reset_mid();
        int k = 0;
        bit found = 1'b0;
        char_ready = 1'b1;
        start      = 1'b1;
        while (!found && k < 2000) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (char_valid && addr == 9'd5 && char_x == 7'(XB + 3)) found = 1'b1;
        end
        check("mid_found", 32'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_valid", 32'(char_valid), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fin", 32'(finished_register), 0);
        check("rst_char", 32'({char_code, char_x, char_y}), 0);
        exp_q.delete();
    endtask

    // Single-register instance, ready tied high.
    task automatic sweep_one();
        int k = 0;
        int nch = 0;
        int fin_cnt = 0;
        int fin_k = 0;
        int addr_bad = 0;
        start1 = 1'b1;
        while (fin_cnt == 0 && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) start1 = 1'b0;
            if (addr1 != 9'd0) addr_bad++;
            if (valid1) begin
                check("n1_char", 32'({code1, x1, y1}), 32'(char_word(32'h0123ABCD, 0, nch % 8)));
                nch++;
            end
            if (fin1) begin
                fin_cnt++;
                fin_k = k;
            end
        end
        check("n1_count", nch, 8);
        check("n1_fin", fin_cnt, 1);
        check("n1_len", fin_k, RL + 9 + 1);
        check("n1_addr", addr_bad, 0);
        @(negedge clk);
        check("n1_idle", 32'({busy1, fin1, addr1}), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        char_ready = 1'b0;
        start1     = 1'b0;
        ready1     = 1'b1;
        rv1        = 32'h0123ABCD;
        for (int i = 0; i < N; i++) regs[i] = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(char_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_addr", 32'(addr), 0);
        check("reset_fin", 32'(finished_register), 0);
        check("reset_char", 32'({char_code, char_x, char_y}), 0);
        reset = 1'b0;

        for (int i = 0; i < N; i++) regs[i] = 32'hFEEDF00D;
        sweep(100, 0);

        for (int i = 0; i < N; i++) regs[i] = 32'(i);
        sweep(100, 0);

        for (int i = 0; i < N; i++) regs[i] = $urandom;
        sweep(30, 0);

        for (int i = 0; i < N; i++) regs[i] = $urandom;
        sweep(100, 50);

        for (int i = 0; i < N; i++) regs[i] = $urandom;
        reset_mid();
        sweep(60, 0);

        sweep_one();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
